// File: rtl/parser_input_scheduler_pkg.sv
// ParserSchedPkg: shared constants, lock-state enum and escape-sequence
// classification used by the parser input scheduler.
package ParserSchedPkg;

  localparam logic [7:0] CH_ESC    = 8'h1B;
  localparam logic [7:0] CSI_INTRO = 8'h5B;
  localparam logic [7:0] FINAL_LO  = 8'h40;
  localparam logic [7:0] FINAL_HI  = 8'h7E;
  localparam logic [7:0] PARAM_LO  = 8'h30;
  localparam logic [7:0] PARAM_HI  = 8'h3F;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_RX   = 2'd1;
  localparam logic [1:0] SRC_LOC  = 2'd2;

  typedef enum logic [1:0] {UNLOCK, ESC, CSI, ONE} SchedLock_t;

  // Intermediates that introduce a single following byte (charset / line attrs).
  function automatic logic is_one_intro(input logic [7:0] b);
    return (b == 8'h28) || (b == 8'h29) || (b == 8'h23) ||
           (b == 8'h2A) || (b == 8'h2B);
  endfunction

  function automatic SchedLock_t lock_next(input SchedLock_t s, input logic [7:0] b);
    SchedLock_t n;
    n = UNLOCK;
    if (b == CH_ESC) begin
      n = ESC;
    end else begin
      case (s)
        ESC: begin
          if (b == CSI_INTRO)    n = CSI;
          else if (is_one_intro(b)) n = ONE;
          else                   n = UNLOCK;
        end
        CSI: begin
          if (b >= FINAL_LO && b <= FINAL_HI)      n = UNLOCK;
          else if (b >= PARAM_LO && b <= PARAM_HI) n = CSI;
          else                                     n = UNLOCK;
        end
        default: n = UNLOCK;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/parser_input_scheduler_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with occupancy count.
// Ports: clk/rst (sync, active-high), clear (synchronous flush, wins over push),
// push/din, pop, dout (head byte, combinational), count, full, empty.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/parser_input_scheduler.sv
// parser_input_scheduler: merges UART rx and local byte streams into the
// escape-sequence parser. Round-robin between two FIFOs, locks onto one source
// for the length of an escape sequence, paces strobes GAP cycles apart.
// Ports: clk/rst; rx_* and loc_* valid/ready byte pushes; flush; exec_busy;
// data/dataReady issue strobe; rx_count/loc_count occupancy; lock_src owner.
module parser_input_scheduler
  import ParserSchedPkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int GAP          = 2,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [7:0]             loc_data,
  input  logic                   loc_valid,
  output logic                   loc_ready,
  input  logic                   flush,
  input  logic                   exec_busy,
  output logic [7:0]             data,
  output logic                   dataReady,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] loc_count,
  output logic [1:0]             lock_src
);
  localparam int GW = $clog2(GAP);

  logic       rx_full, rx_empty, loc_full, loc_empty;
  logic [7:0] rx_head, loc_head, head;
  logic       grant_rx, grant_empty, issue;

  logic [GW-1:0] gap_cnt;
  logic          last_rx;
  SchedLock_t    lock_q, lock_d;
  logic          owner_rx_q, owner_rx_d;
  logic [7:0]    tmo_q, tmo_d;

  assign rx_ready  = !rx_full && !flush && !rst;
  assign loc_ready = !loc_full && !flush && !rst;

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .clear(flush),
    .push(rx_valid && rx_ready), .din(rx_data),
    .pop(issue && grant_rx), .dout(rx_head),
    .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_loc_fifo (
    .clk(clk), .rst(rst), .clear(flush),
    .push(loc_valid && loc_ready), .din(loc_data),
    .pop(issue && !grant_rx), .dout(loc_head),
    .count(loc_count), .full(loc_full), .empty(loc_empty)
  );

  // Arbitration: locked owner only; otherwise round-robin, source not issued
  // last wins when both hold data.
  always_comb begin
    grant_rx = 1'b0;
    if (lock_q != UNLOCK)              grant_rx = owner_rx_q;
    else if (!rx_empty && !loc_empty)  grant_rx = !last_rx;
    else                               grant_rx = !rx_empty;
    grant_empty = grant_rx ? rx_empty : loc_empty;
    head        = grant_rx ? rx_head : loc_head;
    issue       = (gap_cnt == '0) && !exec_busy && !flush && !grant_empty;
  end

  // Lock FSM next state, including stall timeout.
  always_comb begin
    lock_d     = lock_q;
    owner_rx_d = owner_rx_q;
    tmo_d      = tmo_q;
    if (flush) begin
      lock_d = UNLOCK;
      tmo_d  = '0;
    end else if (issue) begin
      lock_d = lock_next(lock_q, head);
      tmo_d  = '0;
      if (lock_q == UNLOCK) owner_rx_d = grant_rx;
    end else if (lock_q != UNLOCK && grant_empty) begin
      if (tmo_q == 8'(LOCK_TIMEOUT - 1)) begin
        lock_d = UNLOCK;
        tmo_d  = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= UNLOCK;
      owner_rx_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      lock_q     <= lock_d;
      owner_rx_q <= owner_rx_d;
      tmo_q      <= tmo_d;
    end
  end

  // Pacing and output register; flush deliberately leaves the gap counter alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt   <= '0;
      last_rx   <= 1'b0;
      dataReady <= 1'b0;
      data      <= '0;
    end else begin
      dataReady <= issue;
      if (issue) begin
        data    <= head;
        last_rx <= grant_rx;
        gap_cnt <= GW'(GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  assign lock_src = (lock_q == UNLOCK) ? SRC_NONE : (owner_rx_q ? SRC_RX : SRC_LOC);
endmodule

// File: tb/tb_parser_input_scheduler.sv
module tb_parser_input_scheduler;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int LT    = 40;

  logic       clk, rst;
  logic [7:0] rx_data, loc_data, data;
  logic       rx_valid, loc_valid, rx_ready, loc_ready;
  logic       flush, exec_busy, dataReady;
  logic [3:0] rx_count, loc_count;
  logic [1:0] lock_src;

  parser_input_scheduler #(.DEPTH(DEPTH), .GAP(GAP), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .loc_data(loc_data), .loc_valid(loc_valid), .loc_ready(loc_ready),
    .flush(flush), .exec_busy(exec_busy),
    .data(data), .dataReady(dataReady),
    .rx_count(rx_count), .loc_count(loc_count), .lock_src(lock_src)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq_rx[$], mq_loc[$];
  logic [7:0] sb[$];          // expected strobe bytes, in order
  bit  m_last_rx;             // rx issued most recently
  int  m_gap, m_owner, m_phase, m_tmo; // phase: 0 none,1 after ESC,2 in CSI,3 one-byte

  function automatic int seq_next(input int phase, input logic [7:0] b);
    if (b == 8'h1B) return 1;
    case (phase)
      1: begin
        if (b == 8'h5B) return 2;
        if (b == 8'h28 || b == 8'h29 || b == 8'h23 || b == 8'h2A || b == 8'h2B) return 3;
        return 0;
      end
      2: return (b >= 8'h30 && b <= 8'h3F) ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_eval();
    bit have_rx, have_loc, acc_rx, acc_loc, has;
    int src;
    logic [7:0] b;
    if (rst) begin
      mq_rx.delete(); mq_loc.delete(); sb.delete();
      m_last_rx = 0; m_gap = 0; m_owner = 0; m_phase = 0; m_tmo = 0;
      return;
    end
    have_rx  = mq_rx.size() > 0;
    have_loc = mq_loc.size() > 0;
    acc_rx   = rx_valid && !flush && mq_rx.size() < DEPTH;
    acc_loc  = loc_valid && !flush && mq_loc.size() < DEPTH;
    if (flush) begin
      mq_rx.delete(); mq_loc.delete();
      m_owner = 0; m_phase = 0; m_tmo = 0;
      if (m_gap > 0) m_gap--;
      return;
    end
    if (m_owner != 0) src = m_owner;
    else if (have_rx && have_loc) src = m_last_rx ? 2 : 1;
    else if (have_rx) src = 1;
    else if (have_loc) src = 2;
    else src = 0;
    has = (src == 1) ? have_rx : (src == 2) ? have_loc : 1'b0;
    if (m_gap == 0 && !exec_busy && has) begin
      b = (src == 1) ? mq_rx.pop_front() : mq_loc.pop_front();
      sb.push_back(b);
      m_last_rx = (src == 1);
      if (m_phase == 0) m_owner = src;
      m_phase = seq_next(m_phase, b);
      if (m_phase == 0) m_owner = 0;
      m_tmo = 0;
      m_gap = GAP - 1;
    end else begin
      if (m_gap > 0) m_gap--;
      if (m_owner != 0 && !has) begin
        m_tmo++;
        if (m_tmo == LT) begin m_owner = 0; m_phase = 0; m_tmo = 0; end
      end
    end
    if (acc_rx)  mq_rx.push_back(rx_data);
    if (acc_loc) mq_loc.push_back(loc_data);
  endtask

  // One clock: model, edge, then compare state-like outputs.
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    chk("rx_count", rx_count, mq_rx.size());
    chk("loc_count", loc_count, mq_loc.size());
    chk("lock_src", lock_src, m_owner);
    chk("rx_ready", rx_ready, (!rst && !flush && mq_rx.size() < DEPTH));
    chk("loc_ready", loc_ready, (!rst && !flush && mq_loc.size() < DEPTH));
  endtask

  // ---------------- monitor ----------------
  logic [7:0] seen[$];
  int seen_cyc[$];
  int last_strobe = -100;

  always @(negedge clk) begin
    if (dataReady) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", data, -1);
      end else begin
        chk("strobe_data", data, sb.pop_front());
      end
      checks++;
      if (cyc - last_strobe < GAP) begin
        failures++;
        $display("FAIL strobe_spacing: got %0d cycles expected >= %0d", cyc - last_strobe, GAP);
      end
      last_strobe = cyc;
      seen.push_back(data);
      seen_cyc.push_back(cyc);
    end
  end

  task automatic idle_inputs();
    rx_valid = 0; loc_valid = 0; flush = 0; exec_busy = 0;
    rx_data = 0; loc_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (3) begin
      step();
      chk("rst_dataReady", dataReady, 0);
      chk("rst_data", data, 0);
    end
    rst = 0;
    #1;
    chk("post_rst_rx_ready", rx_ready, 1);
    chk("post_rst_loc_ready", loc_ready, 1);
    seen.delete(); seen_cyc.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    idle_inputs();
    while ((sb.size() != 0 || mq_rx.size() != 0 || mq_loc.size() != 0) && n < budget) begin
      step(); n++;
    end
    step(); step();
    chk("drain_done", sb.size() + mq_rx.size() + mq_loc.size(), 0);
  endtask

  task automatic check_seen(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, seen.size(), exp.size());
    foreach (exp[i]) if (i < seen.size()) chk(name, seen[i], exp[i]);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom % 10)
      0, 1:    return 8'h1B;
      2:       return 8'h5B;
      3:       return 8'h28;
      4:       return 8'h30 + 8'($urandom % 16);
      5:       return 8'h48;
      6:       return 8'h3B;
      default: return 8'($urandom % 256);
    endcase
  endfunction

  initial begin
    int t;
    logic [7:0] e[$];
    rst = 1;
    idle_inputs();

    // Two bytes on rx: latency 2, spacing 2.
    do_reset();
    t = cyc;
    rx_valid = 1; rx_data = 8'h41; step();
    rx_data = 8'h42; step();
    drain(50);
    e = '{8'h41, 8'h42};
    check_seen("ab_order", e);
    if (seen_cyc.size() == 2) begin
      chk("ab_latency", seen_cyc[0] - t, 2);
      chk("ab_spacing", seen_cyc[1] - seen_cyc[0], 2);
    end
    chk("ab_rx_count", rx_count, 0);

    // Plain bytes alternate, rx first.
    do_reset();
    exec_busy = 1;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1; rx_data = 8'h61 + 8'(i);
      loc_valid = 1; loc_data = 8'h78 + 8'(i);
      step();
    end
    drain(100);
    e = '{8'h61, 8'h78, 8'h62, 8'h79, 8'h63, 8'h7A};
    check_seen("rr_order", e);

    // CSI sequence on rx holds off loc.
    do_reset();
    exec_busy = 1;
    e = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h32, 8'h48};
    foreach (e[i]) begin
      rx_valid = 1; rx_data = e[i];
      loc_valid = (i == 0); loc_data = 8'h78;
      step();
    end
    drain(100);
    e.push_back(8'h78);
    check_seen("csi_order", e);

    // Stalled sequence times out, then loc gets through.
    do_reset();
    exec_busy = 1;
    e = '{8'h1B, 8'h5B, 8'h31};
    foreach (e[i]) begin
      rx_valid = 1; rx_data = e[i];
      loc_valid = (i == 0); loc_data = 8'h79;
      step();
    end
    drain(LT + 60);
    e.push_back(8'h79);
    check_seen("tmo_order", e);
    if (seen_cyc.size() == 4) begin
      checks++;
      if (seen_cyc[3] - seen_cyc[2] < LT || seen_cyc[3] - seen_cyc[2] > LT + 2) begin
        failures++;
        $display("FAIL tmo_delay: got %0d cycles expected %0d..%0d",
                 seen_cyc[3] - seen_cyc[2], LT, LT + 2);
      end
    end
    chk("tmo_lock_src", lock_src, 0);

    // Fill, push against full while popping, then flush.
    do_reset();
    exec_busy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1; rx_data = 8'h10 + 8'(i); step();
    end
    chk("full_rx_ready", rx_ready, 0);
    exec_busy = 0; rx_data = 8'hEE; step();
    chk("full_push_rejected", rx_count, DEPTH - 1);
    rx_valid = 0; flush = 1; step();
    chk("flush_rx_count", rx_count, 0);
    chk("flush_lock_src", lock_src, 0);
    flush = 0;
    #1;
    chk("after_flush_ready", rx_ready, 1);
    rx_valid = 1; rx_data = 8'h55; step();
    chk("after_flush_push", rx_count, 1);
    drain(50);
    e = '{8'h10, 8'h55};
    check_seen("flush_order", e);

    // exec_busy holds issue off.
    do_reset();
    exec_busy = 1;
    rx_valid = 1; rx_data = 8'h51; step();
    rx_valid = 0;
    for (int i = 0; i < 8; i++) step();
    t = cyc; step();
    chk("busy_no_strobe", seen.size(), 0);
    drain(50);
    if (seen_cyc.size() == 1) chk("busy_release_delay", seen_cyc[0] - t, 2);
    else chk("busy_strobe_count", seen.size(), 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rx_valid  = ($urandom % 3) == 0; rx_data  = pick();
      loc_valid = ($urandom % 3) == 0; loc_data = pick();
      exec_busy = ($urandom % 8) == 0;
      flush     = ($urandom % 200) == 0;
      step();
    end
    drain(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parser_input_scheduler.md
# parser_input_scheduler

Shares the terminal escape-sequence parser between two byte sources: the host UART receive stream and a local injector (keyboard echo / answer-back). It buffers each source in its own FIFO, arbitrates round-robin between them, and never interleaves bytes of two sources inside one escape sequence. Bytes go to the parser as single-cycle `dataReady` strobes, spaced so that every byte reaches the parser's command stage. It sits between the UART/keyboard front-ends and the parser.

## Interface
Parameters:
- `DEPTH`, 8: entries per source FIFO; power of two, ≥2.
- `GAP`, 2: minimum cycles between consecutive `dataReady` pulses; ≥2.
- `LOCK_TIMEOUT`, 255: idle cycles before a stalled sequence lock is released; 1..255.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - `clk` in 1: clock.
  - `rst` in 1: reset.
- `rx_data` in 8 / `rx_valid` in 1 / `rx_ready` out 1: UART byte push; accepted when valid&ready.
- `loc_data` in 8 / `loc_valid` in 1 / `loc_ready` out 1: local byte push, same rules.
- `flush` in 1: clears both FIFOs and the lock.
- `exec_busy` in 1: downstream command executor busy; no issue while high.
- `data` out 8: byte to the parser; valid only while `dataReady`=1.
- `dataReady` out 1: one-cycle issue strobe.
- `rx_count`, `loc_count` out $clog2(DEPTH)+1: FIFO occupancy.
- `lock_src` out 2: 0 = unlocked, 1 = locked to rx, 2 = locked to loc.

## Operation
- FIFOs:
  - `*_ready` = !full && !flush && !rst.
  - A push to a full FIFO is never accepted, even when a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO leave the count unchanged.
- Issue condition: gap counter = 0, `exec_busy`=0, `flush`=0, and the granted source is non-empty. When met:
  - the head byte is popped;
  - `data`/`dataReady` are driven in the next cycle;
  - the gap counter is loaded with GAP-1.
- Grant when unlocked: round-robin among non-empty sources. The source not issued last wins ties. After reset, rx has priority.
- Grant when locked: only the locked source. The other source waits even if non-empty.
- Lock FSM, advanced on every issued byte of the granted source:
  - UNLOCK: byte 0x1B → ESC.
  - ESC:
    - 0x5B '[' → CSI;
    - 0x28, 0x29, 0x23, 0x2A, 0x2B → ONE;
    - any other byte → UNLOCK.
  - CSI:
    - bytes 0x30–0x3F (digits, ';', '?') stay in CSI;
    - 0x40–0x7E → UNLOCK;
    - any other byte → UNLOCK.
  - ONE: any byte → UNLOCK.
  - A byte 0x1B in any locked state → ESC. The lock stays with the same source.
- Timeout:
  - While locked, a counter increments each cycle the locked source is empty.
  - It resets on each issue from that source.
  - Reaching LOCK_TIMEOUT → UNLOCK.
- Flush:
  - Empties both FIFOs, forces UNLOCK, and clears the timeout counter.
  - Does not clear the gap counter.
  - Blocks pops that cycle; an issue decided the previous cycle still completes.
  - Flush wins over a same-cycle push, which is not accepted.

## Timing
- Reset values: `dataReady`=0, `data`=0x00, `rx_ready`=`loc_ready`=0 during rst and 1 afterwards, counts 0, `lock_src`=0, gap counter 0, round-robin pointer = rx.
- Latency:
  - A byte pushed at cycle t can appear on `dataReady` at t+2 at the earliest: FIFO write at t, pop decision at t+1, output register at t+2.
- Throughput: one byte per GAP cycles.
  - With GAP=2 the parser always sees an idle cycle after each strobe.
  - This idle cycle gives the parser's one-cycle `commandReady` time to clear.
- `exec_busy` is sampled only in the pop-decision cycle. A strobe already registered is not withdrawn.
- `lock_src` updates in the cycle after the issued byte is popped.

## Structure
- Shared package `ParserSchedPkg`:
  - ASCII constants ESC=0x1B, CSI_INTRO=0x5B, final-byte range 0x40–0x7E, one-byte intro set;
  - enum `SchedLock_t` {UNLOCK, ESC, CSI, ONE};
  - source ID constants.
- Sub-module `byte_fifo` (synchronous FIFO with count, full and empty outputs), instantiated twice. Arbiter, lock FSM and pacing live in the top module.

## Test plan
- Reset, then push 'A','B' on rx → `dataReady` strobes with 0x41 then 0x42, exactly 2 cycles apart; `rx_count` returns to 0.
- rx and loc each hold 3 bytes, no escape sequences → output alternates rx, loc, rx, loc, rx, loc starting with rx.
- rx holds 1B 5B 31 3B 32 48 and loc holds 'x' → all six rx bytes are issued before 'x'; `lock_src`=1 until after 0x48.
- rx holds 1B 5B 31 only, loc holds 'y' → 'y' is issued LOCK_TIMEOUT cycles after rx empties, and `lock_src` returns to 0.
- Fill rx to DEPTH → `rx_ready`=0; a push held while popping is not accepted; assert `flush` → counts 0, `lock_src`=0, pushes accepted the cycle after.
- Hold `exec_busy`=1 for 10 cycles with rx non-empty → no strobes; the first strobe comes 2 cycles after `exec_busy` falls.
